// File: rtl/video_mode_ctrl.sv
// ---------------------------------------------------------------------------
// video_mode_ctrl
//
// Runtime video-mode controller for the display timing path. It holds a
// small table of timing modes and drives the programmable horizontal and
// vertical fields of a downstream timing generator. A mode-change request
// waits for a frame boundary. The generator is then held in reset for
// QUIET_CYC cycles while the new fields settle. The controller releases the
// generator and acknowledges once the first frame in the new mode starts.
//
// Optional feature macro: VMODE_1080P_EN
//   defined   : mode 2 (1080p60) is valid and selectable
//   undefined : mode 2 is rejected like mode 3, its table entry is not
//               built, and DEF_MODE=2 falls back to mode 0
//
// Parameters
//   X_BITS    : width of the horizontal timing fields
//   Y_BITS    : width of the vertical timing fields
//   QUIET_CYC : cycles the generator is held in reset during a switch (>=2)
//   DEF_MODE  : mode loaded at reset
//
// Ports
//   clk        in   pixel clock
//   rstn       in   asynchronous active-low reset
//   mode_req   in   single-cycle request pulse
//   mode_sel   in   requested mode, sampled with mode_req
//   mode_ack   out  one-cycle pulse, switch complete
//   mode_err   out  one-cycle pulse, request rejected
//   busy       out  switch in progress
//   cur_mode   out  mode currently running
//   tg_vs      in   vertical sync from the timing generator
//   tg_rstn    out  active-low reset to the timing generator
//   h_*        out  horizontal timing fields (total/fp/bp/sync/act)
//   v_*        out  vertical timing fields (total/fp/bp/sync/act)
// ---------------------------------------------------------------------------
module video_mode_ctrl #(
  parameter int X_BITS    = 12,
  parameter int Y_BITS    = 12,
  parameter int QUIET_CYC = 16,
  parameter int DEF_MODE  = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mode_req,
  input  logic [1:0]        mode_sel,
  output logic              mode_ack,
  output logic              mode_err,
  output logic              busy,
  output logic [1:0]        cur_mode,
  input  logic              tg_vs,
  output logic              tg_rstn,
  output logic [X_BITS-1:0] h_total,
  output logic [X_BITS-1:0] h_fp,
  output logic [X_BITS-1:0] h_bp,
  output logic [X_BITS-1:0] h_sync,
  output logic [X_BITS-1:0] h_act,
  output logic [Y_BITS-1:0] v_total,
  output logic [Y_BITS-1:0] v_fp,
  output logic [Y_BITS-1:0] v_bp,
  output logic [Y_BITS-1:0] v_sync,
  output logic [Y_BITS-1:0] v_act
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FRAME = 2'd1,
    S_HOLD       = 2'd2,
    S_START      = 2'd3
  } state_t;

  localparam int CNT_W = (QUIET_CYC > 2) ? $clog2(QUIET_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUIET_CYC - 1);

  // Reset mode after folding unsupported or reserved selections to mode 0.
`ifdef VMODE_1080P_EN
  localparam logic [1:0] DEF_SEL = (DEF_MODE == 1) ? 2'd1 :
                                   (DEF_MODE == 2) ? 2'd2 : 2'd0;
`else
  localparam logic [1:0] DEF_SEL = (DEF_MODE == 1) ? 2'd1 : 2'd0;
`endif

  // Mode 3 is reserved; mode 2 exists only when the 1080p entry is built.
  function automatic logic mode_valid(input logic [1:0] m);
    logic v;
    case (m)
      2'd0:    v = 1'b1;
      2'd1:    v = 1'b1;
`ifdef VMODE_1080P_EN
      2'd2:    v = 1'b1;
`endif
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Horizontal entry packed as {total, fp, bp, sync, act}.
  function automatic logic [5*X_BITS-1:0] h_entry(input logic [1:0] m);
    logic [5*X_BITS-1:0] e;
    case (m)
      2'd1:    e = {X_BITS'(16'd800),  X_BITS'(16'd16), X_BITS'(16'd48),
                    X_BITS'(16'd96),   X_BITS'(16'd640)};
`ifdef VMODE_1080P_EN
      2'd2:    e = {X_BITS'(16'd2200), X_BITS'(16'd88), X_BITS'(16'd148),
                    X_BITS'(16'd44),   X_BITS'(16'd1920)};
`endif
      default: e = {X_BITS'(16'd1650), X_BITS'(16'd110), X_BITS'(16'd220),
                    X_BITS'(16'd40),   X_BITS'(16'd1280)};
    endcase
    return e;
  endfunction

  // Vertical entry packed as {total, fp, bp, sync, act}.
  function automatic logic [5*Y_BITS-1:0] v_entry(input logic [1:0] m);
    logic [5*Y_BITS-1:0] e;
    case (m)
      2'd1:    e = {Y_BITS'(16'd525),  Y_BITS'(16'd10), Y_BITS'(16'd33),
                    Y_BITS'(16'd2),    Y_BITS'(16'd480)};
`ifdef VMODE_1080P_EN
      2'd2:    e = {Y_BITS'(16'd1125), Y_BITS'(16'd4),  Y_BITS'(16'd36),
                    Y_BITS'(16'd5),    Y_BITS'(16'd1080)};
`endif
      default: e = {Y_BITS'(16'd750),  Y_BITS'(16'd5),  Y_BITS'(16'd20),
                    Y_BITS'(16'd5),    Y_BITS'(16'd720)};
    endcase
    return e;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                boot_q, boot_d;
  logic [1:0]          pend_q, pend_d;
  logic [1:0]          cur_mode_q, cur_mode_d;
  logic                tg_rstn_q, tg_rstn_d;
  logic                busy_q, busy_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                vs_dly_q;      // tg_vs delayed one cycle (vs_d)
  logic [5*X_BITS-1:0] hfield_q, hfield_d;
  logic [5*Y_BITS-1:0] vfield_q, vfield_d;
  logic                vs_rise;

  assign vs_rise = tg_vs & ~vs_dly_q;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      boot_q     <= 1'b1;
      pend_q     <= DEF_SEL;
      cur_mode_q <= DEF_SEL;
      tg_rstn_q  <= 1'b0;
      busy_q     <= 1'b1;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      vs_dly_q   <= 1'b0;
      hfield_q   <= h_entry(DEF_SEL);
      vfield_q   <= v_entry(DEF_SEL);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      boot_q     <= boot_d;
      pend_q     <= pend_d;
      cur_mode_q <= cur_mode_d;
      tg_rstn_q  <= tg_rstn_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      vs_dly_q   <= tg_vs;
      hfield_q   <= hfield_d;
      vfield_q   <= vfield_d;
    end
  end

  // Next-state and next-output logic of the switch sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    boot_d     = boot_q;
    pend_d     = pend_q;
    cur_mode_d = cur_mode_q;
    tg_rstn_d  = tg_rstn_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    hfield_d   = hfield_q;
    vfield_d   = vfield_q;

    case (state_q)
      S_IDLE: begin
        if (mode_req) begin
          if (!mode_valid(mode_sel)) begin
            err_d = 1'b1;
          end else if (mode_sel == cur_mode_q) begin
            // Already running the requested mode: acknowledge at once.
            ack_d = 1'b1;
          end else begin
            pend_d  = mode_sel;
            state_d = S_WAIT_FRAME;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WAIT_FRAME: begin
        if (vs_rise) begin
          // Frame boundary: freeze the generator and load the new fields.
          state_d   = S_HOLD;
          tg_rstn_d = 1'b0;
          cnt_d     = '0;
          hfield_d  = h_entry(pend_q);
          vfield_d  = v_entry(pend_q);
        end else begin
          state_d = S_WAIT_FRAME;
        end
      end

      S_HOLD: begin
        tg_rstn_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
          state_d   = S_START;
          tg_rstn_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_START: begin
        if (vs_rise) begin
          // First frame in the new mode; the power-up release is silent.
          ack_d      = ~boot_q;
          cur_mode_d = pend_q;
          boot_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_START;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign mode_ack = ack_q;
  assign mode_err = err_q;
  assign busy     = busy_q;
  assign cur_mode = cur_mode_q;
  assign tg_rstn  = tg_rstn_q;

  assign h_total = hfield_q[5*X_BITS-1:4*X_BITS];
  assign h_fp    = hfield_q[4*X_BITS-1:3*X_BITS];
  assign h_bp    = hfield_q[3*X_BITS-1:2*X_BITS];
  assign h_sync  = hfield_q[2*X_BITS-1:1*X_BITS];
  assign h_act   = hfield_q[1*X_BITS-1:0];

  assign v_total = vfield_q[5*Y_BITS-1:4*Y_BITS];
  assign v_fp    = vfield_q[4*Y_BITS-1:3*Y_BITS];
  assign v_bp    = vfield_q[3*Y_BITS-1:2*Y_BITS];
  assign v_sync  = vfield_q[2*Y_BITS-1:1*Y_BITS];
  assign v_act   = vfield_q[1*Y_BITS-1:0];

endmodule

// File: tb/tb_video_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_video_mode_ctrl
//
// Directed bench for video_mode_ctrl (QUIET_CYC=16, DEF_MODE=0). Inputs change
// and outputs are sampled on the falling clock edge, half a cycle away from
// the active edge. Expected values are the hand-written mode table figures.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_video_mode_ctrl;

  logic        clk;
  logic        rstn;
  logic        mode_req;
  logic [1:0]  mode_sel;
  logic        mode_ack;
  logic        mode_err;
  logic        busy;
  logic [1:0]  cur_mode;
  logic        tg_vs;
  logic        tg_rstn;
  logic [11:0] h_total, h_fp, h_bp, h_sync, h_act;
  logic [11:0] v_total, v_fp, v_bp, v_sync, v_act;

  int vectors;
  int miscompares;
  int ack_cnt;
  int err_cnt;
  int low_cnt;

  video_mode_ctrl #(
    .X_BITS(12), .Y_BITS(12), .QUIET_CYC(16), .DEF_MODE(0)
  ) dut (
    .clk(clk), .rstn(rstn), .mode_req(mode_req), .mode_sel(mode_sel),
    .mode_ack(mode_ack), .mode_err(mode_err), .busy(busy),
    .cur_mode(cur_mode), .tg_vs(tg_vs), .tg_rstn(tg_rstn),
    .h_total(h_total), .h_fp(h_fp), .h_bp(h_bp), .h_sync(h_sync),
    .h_act(h_act), .v_total(v_total), .v_fp(v_fp), .v_bp(v_bp),
    .v_sync(v_sync), .v_act(v_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one-cycle pulses seen at each active edge.
  always @(posedge clk) begin
    if (mode_ack === 1'b1) ack_cnt <= ack_cnt + 1;
    if (mode_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Counts falling edges with tg_rstn low, starting at the current one.
  task automatic count_low();
    low_cnt = 0;
    while (tg_rstn === 1'b0 && low_cnt < 100) begin
      low_cnt++;
      step();
    end
  endtask

  // Single-cycle frame-start pulse on tg_vs.
  task automatic vs_pulse();
    tg_vs = 1'b1;
    step();
    tg_vs = 1'b0;
  endtask

  // Full switch to a new mode with checks on every phase.
  task automatic switch_to(input logic [1:0] sel, input int exp_ht,
                           input int exp_vt, input logic [1:0] prev_mode,
                           input int prev_ht, input logic extra_req);
    int acks_before;
    acks_before = ack_cnt;
    mode_req = 1'b1; mode_sel = sel;
    step();
    mode_req = 1'b0;
    check("sw_busy_t1", busy, 1);
    check("sw_noack_t1", mode_ack, 0);
    step();
    if (extra_req) begin
      mode_req = 1'b1; mode_sel = 2'd3;
      step();
      mode_req = 1'b0;
      step();
      check("sw_extra_noerr", mode_err, 0);
    end else begin
      step();
    end
    check("sw_wait_tgrstn", tg_rstn, 1);
    check("sw_wait_htotal", h_total, prev_ht);
    vs_pulse();
    check("sw_hold_tgrstn", tg_rstn, 0);
    check("sw_new_htotal", h_total, exp_ht);
    check("sw_new_vtotal", v_total, exp_vt);
    count_low();
    check("sw_low_cycles", low_cnt, 16);
    check("sw_start_busy", busy, 1);
    check("sw_start_cur", cur_mode, prev_mode);
    step(); step();
    vs_pulse();
    check("sw_ack", mode_ack, 1);
    check("sw_cur_mode", cur_mode, sel);
    check("sw_busy_fall", busy, 0);
    step();
    check("sw_ack_width", mode_ack, 0);
    check("sw_ack_count", ack_cnt - acks_before, 1);
  endtask

  initial begin
    vectors = 0; miscompares = 0; ack_cnt = 0; err_cnt = 0; low_cnt = 0;
    rstn = 1'b0; mode_req = 1'b0; mode_sel = 2'd0; tg_vs = 1'b0;
    step(); step();

    // Reset state: mode 0 fields, generator held, busy.
    check("rst_tgrstn", tg_rstn, 0);
    check("rst_busy", busy, 1);
    check("rst_ack", mode_ack, 0);
    check("rst_err", mode_err, 0);
    check("rst_cur", cur_mode, 0);
    check("rst_h_total", h_total, 1650);
    check("rst_h_fp", h_fp, 110);
    check("rst_h_bp", h_bp, 220);
    check("rst_h_sync", h_sync, 40);
    check("rst_h_act", h_act, 1280);
    check("rst_v_total", v_total, 750);
    check("rst_v_fp", v_fp, 5);
    check("rst_v_bp", v_bp, 20);
    check("rst_v_sync", v_sync, 5);
    check("rst_v_act", v_act, 720);

    // Boot: 16 low cycles counted from release, silent release on vs.
    rstn = 1'b1;
    count_low();
    check("boot_low_cycles", low_cnt, 16);
    check("boot_busy_start", busy, 1);
    step();
    vs_pulse();
    check("boot_busy_fall", busy, 0);
    check("boot_no_ack", mode_ack, 0);
    step();
    check("boot_ack_count", ack_cnt, 0);
    check("boot_cur", cur_mode, 0);

    // 0 -> 1 with an ignored request during WAIT_FRAME.
    switch_to(2'd1, 800, 525, 2'd0, 1650, 1'b1);
    check("m1_h_fp", h_fp, 16);
    check("m1_h_bp", h_bp, 48);
    check("m1_h_sync", h_sync, 96);
    check("m1_h_act", h_act, 640);
    check("m1_v_fp", v_fp, 10);
    check("m1_v_bp", v_bp, 33);
    check("m1_v_sync", v_sync, 2);
    check("m1_v_act", v_act, 480);
    check("m1_err_count", err_cnt, 0);

    // Reserved mode 3 rejected.
    mode_req = 1'b1; mode_sel = 2'd3;
    step();
    mode_req = 1'b0;
    check("m3_err", mode_err, 1);
    check("m3_noack", mode_ack, 0);
    check("m3_busy", busy, 0);
    check("m3_tgrstn", tg_rstn, 1);
    check("m3_htotal", h_total, 800);
    step();
    check("m3_err_width", mode_err, 0);
    check("m3_cur", cur_mode, 1);

    // Same mode: immediate ack, no switch.
    mode_req = 1'b1; mode_sel = 2'd1;
    step();
    mode_req = 1'b0;
    check("same_ack", mode_ack, 1);
    check("same_err", mode_err, 0);
    check("same_busy", busy, 0);
    check("same_tgrstn", tg_rstn, 1);
    step();
    check("same_ack_width", mode_ack, 0);
    check("same_tgrstn2", tg_rstn, 1);

`ifdef VMODE_1080P_EN
    switch_to(2'd2, 2200, 1125, 2'd1, 800, 1'b0);
    check("m2_h_act", h_act, 1920);
    check("m2_v_act", v_act, 1080);
    switch_to(2'd0, 1650, 750, 2'd2, 2200, 1'b0);
`else
    mode_req = 1'b1; mode_sel = 2'd2;
    step();
    mode_req = 1'b0;
    check("m2_err", mode_err, 1);
    check("m2_busy", busy, 0);
    check("m2_htotal", h_total, 800);
    step();
    check("m2_cur", cur_mode, 1);
    check("m2_busy2", busy, 0);
    switch_to(2'd0, 1650, 750, 2'd1, 800, 1'b0);
`endif

    // Reset during HOLD of a 0 -> 1 switch abandons it.
    ack_cnt = 0;
    mode_req = 1'b1; mode_sel = 2'd1;
    step();
    mode_req = 1'b0;
    step();
    vs_pulse();
    check("ab_hold_htotal", h_total, 800);
    step(); step(); step();
    rstn = 1'b0;
    #1;
    check("ab_rst_htotal", h_total, 1650);
    check("ab_rst_vtotal", v_total, 750);
    check("ab_rst_tgrstn", tg_rstn, 0);
    check("ab_rst_busy", busy, 1);
    step();
    rstn = 1'b1;
    count_low();
    check("ab_low_cycles", low_cnt, 16);
    step();
    vs_pulse();
    check("ab_busy_fall", busy, 0);
    check("ab_no_ack", mode_ack, 0);
    check("ab_cur", cur_mode, 0);
    step(); step();
    check("ab_ack_count", ack_cnt, 0);
    check("ab_htotal_end", h_total, 1650);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/video_mode_ctrl.md
# video_mode_ctrl

Runtime video-mode controller for the display timing path. It holds a table of timing modes and drives the programmable horizontal and vertical timing fields of the downstream timing generator. It accepts mode-change requests, waits for a frame boundary, and holds the generator in reset while the new fields settle. It then releases the generator and acknowledges once the first frame in the new mode has started.

## Interface
- X_BITS, 12, width of the horizontal timing fields
- Y_BITS, 12, width of the vertical timing fields
- QUIET_CYC, 16, number of cycles the generator is held in reset during a switch (≥2)
- DEF_MODE, 0, mode loaded at reset
- clk  in  1  pixel clock
- rstn  in  1  asynchronous active-low reset
- mode_req  in  1  single-cycle request pulse
- mode_sel  in  2  requested mode, sampled with mode_req
- mode_ack  out  1  one-cycle pulse: switch complete
- mode_err  out  1  one-cycle pulse: request rejected
- busy  out  1  switch in progress
- cur_mode  out  2  mode currently running
- tg_vs  in  1  vertical sync from the timing generator
- tg_rstn  out  1  active-low reset to the timing generator
- h_total, h_fp, h_bp, h_sync, h_act  out  X_BITS each  horizontal timing fields
- v_total, v_fp, v_bp, v_sync, v_act  out  Y_BITS each  vertical timing fields

## Operation
- Mode table. Values are listed as total/fp/bp/sync/act, horizontal then vertical.
  - Mode 0 (720p60): 1650/110/220/40/1280 and 750/5/20/5/720.
  - Mode 1 (480p60): 800/16/48/96/640 and 525/10/33/2/480.
  - Mode 2 (1080p60): 2200/88/148/44/1920 and 1125/4/36/5/1080.
  - Mode 3: reserved.
- tg_vs is registered once into vs_d. The frame-start event is vs_rise = tg_vs & ~vs_d.
- State machine:
  - IDLE (busy=0).
    - mode_req with an invalid mode_sel: pulse mode_err and stay in IDLE.
    - mode_req with mode_sel == cur_mode: pulse mode_ack and stay in IDLE.
    - Any other valid mode_req: latch mode_sel into pend and go to WAIT_FRAME.
  - WAIT_FRAME: on vs_rise go to HOLD.
    - On that same edge: tg_rstn goes to 0, all timing fields load from the table entry for pend, and the quiet counter clears.
  - HOLD: tg_rstn=0 and the counter increments.
    - When the counter reaches QUIET_CYC-1, go to START with tg_rstn=1.
  - START: on the first vs_rise, pulse mode_ack (unless the boot flag is set), set cur_mode=pend, clear the boot flag, and go to IDLE.
- mode_req pulses outside IDLE are ignored. They produce no ack and no err.
- Boot sequence: reset state is HOLD with the boot flag set, so the generator is released after power-up without a mode_ack.
- Timing fields are registered and change only on the WAIT_FRAME→HOLD edge or at reset. They are constant while tg_rstn=1.
- Reset values:
  - state HOLD, counter 0, boot flag 1.
  - tg_rstn=0, busy=1, mode_ack=0, mode_err=0.
  - cur_mode=pend=DEF_MODE, fields = DEF_MODE entry, vs_d=0.
- Reset asserted mid-switch abandons the pending request. No ack is issued for it.

## Timing
- mode_req at cycle t (valid, new mode): busy=1 from t+1.
- mode_ack and mode_err appear at t+1 for the immediate cases.
- vs_rise at cycle f in WAIT_FRAME: tg_rstn=0 and new fields appear from f+1. tg_rstn stays low for exactly QUIET_CYC cycles.
- mode_ack, the cur_mode update and busy falling all occur in the same cycle, one cycle after the vs_rise detected in START.
- mode_ack and mode_err are never asserted together. Each is exactly one cycle wide.

## Configuration
- VMODE_1080P_EN defined: mode 2 is valid and selectable.
- VMODE_1080P_EN undefined:
  - Mode 2 is treated as invalid, like mode 3: mode_err is pulsed and there is no state change.
  - The table entry for mode 2 is not synthesized.
  - DEF_MODE=2 falls back to mode 0.

## Test plan
- Reset with DEF_MODE=0, then release rstn: fields are 1650/110/220/40/1280 and 750/5/20/5/720; tg_rstn stays 0 for 16 cycles then goes to 1; busy falls on the first vs_rise; mode_ack never pulses.
- With a behavioural generator running mode 0, pulse mode_sel=1:
  - tg_rstn drops 1 cycle after the next vs rise and stays low for 16 cycles.
  - h_total=800 and v_total=525 at that point.
  - mode_ack pulses one cycle after the first new vs rise, and cur_mode=1.
- Pulse mode_sel=3: mode_err is high for 1 cycle; busy, tg_rstn and the fields are unchanged.
- Pulse mode_sel equal to cur_mode: mode_ack at t+1, and tg_rstn stays 1.
- Pulse mode_sel=2 with VMODE_1080P_EN: switch completes with h_total=2200 and v_total=1125. Without the macro: mode_err pulses and nothing changes.
- Assert rstn during HOLD of a 0→1 switch: fields revert to mode 0 immediately, tg_rstn=0, and no mode_ack is seen for the abandoned request.
- Send a second mode_req during WAIT_FRAME: it is ignored and only one ack is produced.
